// File: rtl/cbb_ecc_dec_pipe_if.sv
// cbb_ecc_dec_pipe_if: codeword-in / result-out handshake bundle
// master drives codewords and consumes results; slave is the decoder
interface cbb_ecc_dec_pipe_if #(
  parameter int DW = 32,
  parameter int EW = 7,
  parameter int TW = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [DW+EW-1:0] din;
  logic [TW-1:0]    in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    dout;
  logic [TW-1:0]    out_tag;
  logic             sec;
  logic             ded;

  modport master (
    output in_valid, din, in_tag, out_ready,
    input  in_ready, out_valid, dout, out_tag,
    input  sec, ded
  );

  modport slave (
    input  in_valid, din, in_tag, out_ready,
    output in_ready, out_valid, dout, out_tag,
    output sec, ded
  );
endinterface

// File: rtl/cbb_ecc_dec_pipe.sv
// cbb_ecc_dec_pipe: 2-stage SECDED decoder, valid/ready, tag, stats
// ports: clk, rst_n, bus (slave), cnt_clr, sec/ded counters, DED log
module cbb_ecc_dec_pipe #(
  parameter int DW = 32,
  parameter int EW = 7,
  parameter int TW = 4,
  parameter int CW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  cbb_ecc_dec_pipe_if.slave bus,
  input  logic              cnt_clr,
  output logic [CW-1:0]     sec_cnt,
  output logic [CW-1:0]     ded_cnt,
  output logic              log_vld,
  output logic [TW-1:0]     log_tag,
  output logic [EW-1:0]     log_syn
);
  localparam int SW = EW - 1;
  localparam logic [SW-1:0] NMAX = SW'(DW + EW - 1);

  if (DW < 1 || DW > 247) begin : g_dw_bad
    $error("cbb_ecc_dec_pipe: DW out of range");
  end
  if ((2 ** SW) < (DW + EW)) begin : g_ew_bad
    $error("cbb_ecc_dec_pipe: EW too small for DW");
  end
  if (TW < 1) begin : g_tw_bad
    $error("cbb_ecc_dec_pipe: TW must be >= 1");
  end

  function automatic int data_pos(input int i);
    int k;
    int r;
    k = 0;
    r = 0;
    for (int q = 3; q < 1024; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (k == i) r = q;
        k++;
      end
    end
    return r;
  endfunction

  logic [SW-1:0] pos_w [DW];
  for (genvar i = 0; i < DW; i++) begin : g_pos
    localparam int P = data_pos(i);
    assign pos_w[i] = SW'(P);
  end

  logic          s1_vld_q, s1_vld_d;
  logic [DW-1:0] s1_dat_q, s1_dat_d;
  logic [TW-1:0] s1_tag_q, s1_tag_d;
  logic [SW-1:0] s1_syn_q, s1_syn_d;
  logic          s1_par_q, s1_par_d;
  logic          s2_vld_q, s2_vld_d;
  logic [DW-1:0] s2_dat_q, s2_dat_d;
  logic [TW-1:0] s2_tag_q, s2_tag_d;
  logic          s2_sec_q, s2_sec_d;
  logic          s2_ded_q, s2_ded_d;
  logic [EW-1:0] s2_syn_q, s2_syn_d;
  logic [CW-1:0] sec_cnt_q, sec_cnt_d;
  logic [CW-1:0] ded_cnt_q, ded_cnt_d;
  logic          log_vld_q, log_vld_d;
  logic [TW-1:0] log_tag_q, log_tag_d;
  logic [EW-1:0] log_syn_q, log_syn_d;

  logic          s2_adv;
  logic          acc;
  logic          xfer;
  logic [SW-1:0] syn;
  logic          par;
  logic [DW-1:0] flip;
  logic [CW-1:0] sec_b;
  logic [CW-1:0] ded_b;

  assign s2_adv       = ~s2_vld_q | bus.out_ready;
  assign bus.in_ready = ~s1_vld_q | s2_adv;
  assign acc          = bus.in_valid & bus.in_ready;
  assign xfer         = s2_vld_q & bus.out_ready;

  // syndrome = stored checks XOR positions of every set data bit
  always_comb begin
    syn = bus.din[DW +: SW];
    for (int i = 0; i < DW; i++)
      syn = syn ^ (pos_w[i] & {SW{bus.din[i]}});
    par = ^bus.din;
  end

  // only in-range data positions can match, so s>N never flips
  always_comb begin
    flip = '0;
    for (int i = 0; i < DW; i++)
      flip[i] = s1_par_q & (pos_w[i] == s1_syn_q);
  end

  always_comb begin
    s1_vld_d = bus.in_ready ? bus.in_valid : s1_vld_q;
    s1_dat_d = s1_dat_q;
    s1_tag_d = s1_tag_q;
    s1_syn_d = s1_syn_q;
    s1_par_d = s1_par_q;
    if (acc) begin
      s1_dat_d = bus.din[DW-1:0];
      s1_tag_d = bus.in_tag;
      s1_syn_d = syn;
      s1_par_d = par;
    end
    s2_vld_d = s2_adv ? s1_vld_q : s2_vld_q;
    s2_dat_d = s2_dat_q;
    s2_tag_d = s2_tag_q;
    s2_sec_d = s2_sec_q;
    s2_ded_d = s2_ded_q;
    s2_syn_d = s2_syn_q;
    if (s2_adv & s1_vld_q) begin
      s2_dat_d = s1_dat_q ^ flip;
      s2_tag_d = s1_tag_q;
      s2_sec_d = s1_par_q & (s1_syn_q <= NMAX);
      s2_ded_d = (|s1_syn_q) &
                 (~s1_par_q | (s1_syn_q > NMAX));
      s2_syn_d = {s1_par_q, s1_syn_q};
    end
  end

  // clear first, then count on top: clr+event lands at 1
  always_comb begin
    sec_b = cnt_clr ? '0 : sec_cnt_q;
    ded_b = cnt_clr ? '0 : ded_cnt_q;
    sec_cnt_d = sec_b;
    ded_cnt_d = ded_b;
    if (xfer & s2_sec_q & ~&sec_b)
      sec_cnt_d = sec_b + CW'(1);
    if (xfer & s2_ded_q & ~&ded_b)
      ded_cnt_d = ded_b + CW'(1);
    log_vld_d = log_vld_q & ~cnt_clr;
    log_tag_d = cnt_clr ? '0 : log_tag_q;
    log_syn_d = cnt_clr ? '0 : log_syn_q;
    if (xfer & s2_ded_q & ~log_vld_d) begin
      log_vld_d = 1'b1;
      log_tag_d = s2_tag_q;
      log_syn_d = s2_syn_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_dat_q  <= '0;
      s1_tag_q  <= '0;
      s1_syn_q  <= '0;
      s1_par_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_dat_q  <= '0;
      s2_tag_q  <= '0;
      s2_sec_q  <= 1'b0;
      s2_ded_q  <= 1'b0;
      s2_syn_q  <= '0;
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
      log_vld_q <= 1'b0;
      log_tag_q <= '0;
      log_syn_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_dat_q  <= s1_dat_d;
      s1_tag_q  <= s1_tag_d;
      s1_syn_q  <= s1_syn_d;
      s1_par_q  <= s1_par_d;
      s2_vld_q  <= s2_vld_d;
      s2_dat_q  <= s2_dat_d;
      s2_tag_q  <= s2_tag_d;
      s2_sec_q  <= s2_sec_d;
      s2_ded_q  <= s2_ded_d;
      s2_syn_q  <= s2_syn_d;
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
      log_vld_q <= log_vld_d;
      log_tag_q <= log_tag_d;
      log_syn_q <= log_syn_d;
    end
  end

  assign bus.out_valid = s2_vld_q;
  assign bus.dout      = s2_dat_q;
  assign bus.out_tag   = s2_tag_q;
  assign bus.sec       = s2_sec_q;
  assign bus.ded       = s2_ded_q;
  assign sec_cnt       = sec_cnt_q;
  assign ded_cnt       = ded_cnt_q;
  assign log_vld       = log_vld_q;
  assign log_tag       = log_tag_q;
  assign log_syn       = log_syn_q;
endmodule

// File: tb/tb_cbb_ecc_dec_pipe.sv
// tb_cbb_ecc_dec_pipe: directed vectors, scoreboard queue + monitor
// expected values are hand-computed for DW=32, EW=7
module tb_cbb_ecc_dec_pipe;
  localparam int DW = 32;
  localparam int EW = 7;
  localparam int TW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] sec_cnt;
  logic [CW-1:0] ded_cnt;
  logic          log_vld;
  logic [TW-1:0] log_tag;
  logic [EW-1:0] log_syn;

  always #5 clk = ~clk;

  cbb_ecc_dec_pipe_if #(.DW(DW), .EW(EW), .TW(TW)) bus ();

  cbb_ecc_dec_pipe #(.DW(DW), .EW(EW), .TW(TW), .CW(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .cnt_clr (cnt_clr),
    .sec_cnt (sec_cnt),
    .ded_cnt (ded_cnt),
    .log_vld (log_vld),
    .log_tag (log_tag),
    .log_syn (log_syn)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    logic          s;
    logic          e;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic send(input logic [6:0]  ecc,
                      input logic [31:0] data,
                      input logic [3:0]  tag,
                      input logic [31:0] xd,
                      input logic        xs,
                      input logic        xe);
    int  n;
    bit  done;
    exp_t e;
    n = 0;
    done = 0;
    e = '{xd, tag, xs, xe};
    @(negedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.din      = {ecc, data};
    bus.in_tag   = tag;
    while (!done && n < 200) begin
      #1;
      if (bus.in_ready) begin
        exp_q.push_back(e);
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    if (!done) chk("send_timeout", 64'd1, 64'd0);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'd1, 64'd0);
    repeat (2) @(negedge clk);
    #4;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) chk("valid_timeout", 64'd1, 64'd0);
  endtask

  // monitor: pop on each transfer, check hold while stalled
  bit   stall_p = 0;
  exp_t held;
  always begin
    exp_t cur;
    exp_t e;
    @(negedge clk);
    #3;
    cur = '{bus.dout, bus.out_tag, bus.sec, bus.ded};
    if (!rst_n) begin
      stall_p = 0;
    end else begin
      if (stall_p) chk("hold", 64'(cur), 64'(held));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'(cur), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out", 64'(cur), 64'(e));
        end
        stall_p = 0;
      end else if (bus.out_valid) begin
        stall_p = 1;
        held = cur;
      end else begin
        stall_p = 0;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [6:0]  s_ecc [8];
  logic [31:0] s_dat [8];

  initial begin
    s_dat = '{32'h0, 32'h1, 32'h2, 32'h3,
              32'h4, 32'h5, 32'h8, 32'h10};
    s_ecc = '{7'h00, 7'h43, 7'h45, 7'h06,
              7'h46, 7'h05, 7'h07, 7'h49};
    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("rst_out", {bus.out_valid, bus.sec, bus.ded,
                    bus.out_tag, bus.dout}, 64'd0);
    chk("rst_cnt", {sec_cnt, ded_cnt}, 64'd0);
    chk("rst_log", {log_vld, log_tag, log_syn}, 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // clean word, latency
    send(7'h43, 32'h1, 4'd1, 32'h1, 1'b0, 1'b0);
    chk("lat_c1", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_c2", 64'(bus.out_valid), 64'd1);
    drain();
    chk("t1_cnt", {sec_cnt, ded_cnt}, 64'd0);

    // data bit 0 flipped
    send(7'h43, 32'h0, 4'd2, 32'h1, 1'b1, 1'b0);
    drain();
    chk("t2_sec_cnt", 64'(sec_cnt), 64'd1);

    // parity bit flipped; top data bit; ecc[5]
    send(7'h03, 32'h1, 4'd3, 32'h1, 1'b1, 1'b0);
    send(7'h26, 32'h0, 4'd4, 32'h8000_0000, 1'b1, 1'b0);
    send(7'h06, 32'h8000_0000, 4'd5,
         32'h8000_0000, 1'b1, 1'b0);
    drain();
    chk("t3_cnt", {sec_cnt, ded_cnt}, {16'd4, 16'd0});

    // double error s=2,p=0 then out-of-range s=63,p=1
    send(7'h42, 32'h0, 4'd5, 32'h0, 1'b0, 1'b1);
    send(7'h7F, 32'h0, 4'd6, 32'h0, 1'b0, 1'b1);
    drain();
    chk("t4_ded_cnt", 64'(ded_cnt), 64'd2);
    chk("t4_log", {log_vld, log_tag, log_syn},
        {1'b1, 4'd5, 7'h02});
    send(7'h42, 32'h0, 4'd7, 32'h0, 1'b0, 1'b1);
    drain();
    chk("t4_log_keep", {ded_cnt, log_tag}, {16'd3, 4'd5});

    // stream under backpressure 1,0,0,...
    fork
      begin
        for (int k = 0; k < 8; k++)
          send(s_ecc[k], s_dat[k], 4'(k + 8),
               s_dat[k], 1'b0, 1'b0);
      end
      begin
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          bus.out_ready = (k % 3 == 0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // both stages full, consumer stalled
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(7'h43, 32'h1, 4'd1, 32'h1, 1'b0, 1'b0);
    send(7'h45, 32'h2, 4'd2, 32'h2, 1'b0, 1'b0);
    #1;
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    repeat (3) @(negedge clk);
    bus.out_ready = 1'b1;
    drain();

    // clear while idle
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #4;
    chk("clr_cnt", {sec_cnt, ded_cnt}, 64'd0);
    chk("clr_log", {log_vld, log_tag, log_syn}, 64'd0);

    // saturation
    for (int k = 0; k < 65535; k++)
      send(7'h43, 32'h0, 4'(k), 32'h1, 1'b1, 1'b0);
    drain();
    chk("sat_ffff", 64'(sec_cnt), 64'hFFFF);
    send(7'h43, 32'h0, 4'd3, 32'h1, 1'b1, 1'b0);
    drain();
    chk("sat_hold", 64'(sec_cnt), 64'hFFFF);

    // clear coincident with SEC transfer
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(7'h43, 32'h0, 4'd3, 32'h1, 1'b1, 1'b0);
    wait_valid();
    bus.out_ready = 1'b1;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #4;
    chk("clr_sec", 64'(sec_cnt), 64'd1);

    // DED logged, then clear coincident with a new DED
    send(7'h42, 32'h0, 4'd8, 32'h0, 1'b0, 1'b1);
    drain();
    chk("log8", {log_vld, log_tag}, {1'b1, 4'd8});
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(7'h7F, 32'h0, 4'd9, 32'h0, 1'b0, 1'b1);
    wait_valid();
    bus.out_ready = 1'b1;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #4;
    chk("clr_ded_log", {ded_cnt, log_vld, log_tag, log_syn},
        {16'd1, 1'b1, 4'd9, 7'h7F});

    // reset with words in flight
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(7'h43, 32'h0, 4'd1, 32'h1, 1'b1, 1'b0);
    send(7'h43, 32'h0, 4'd2, 32'h1, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_cnt", {sec_cnt, ded_cnt, log_vld},
        64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    #4;
    chk("post_rst", {bus.out_valid, bus.in_ready},
        {1'b0, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
